// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared entry type, default depth and pop-request decode for the issue queue
package issue_queue_pkg;
  localparam int IQ_DEPTH = 8;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;
  // pop=3 is not a legal request; it is treated as a two-entry pop
  function automatic logic [1:0] clamp_pop(input logic [1:0] pop);
    return pop == 2'd3 ? 2'd2 : pop;
  endfunction
endpackage

// File: rtl/issue_queue_perf.sv
// issue_queue_perf: free-running dual/single-issue and empty-cycle counters (built only with ISSUEQ_PERF_EN)
module issue_queue_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pop_eff_i,
  input  logic        empty_i,
  output logic [31:0] dual_o,
  output logic [31:0] single_o,
  output logic [31:0] empty_o
);
  logic [31:0] dual_q, single_q, empty_q;
  // counters wrap naturally and are untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dual_q   <= '0;
      single_q <= '0;
      empty_q  <= '0;
    end else begin
      if (pop_eff_i == 2'd2) dual_q <= dual_q + 32'd1;
      if (pop_eff_i == 2'd1) single_q <= single_q + 32'd1;
      if (empty_i) empty_q <= empty_q + 32'd1;
    end
  end
  assign dual_o   = dual_q;
  assign single_o = single_q;
  assign empty_o  = empty_q;
endmodule

// File: rtl/issue_queue.sv
// issue_queue: 2-in/2-out circular instruction buffer between fetch and dual-issue; ISSUEQ_PERF_EN adds perf counters
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       fetch_valid,
  input  logic [31:0]      fetch_instr0,
  input  logic [31:0]      fetch_pc0,
  input  logic [31:0]      fetch_instr1,
  input  logic [31:0]      fetch_pc1,
  output logic             fetch_ready,
  output logic             out_valid0,
  output logic [31:0]      out_instr0,
  output logic [31:0]      out_pc0,
  output logic             out_valid1,
  output logic [31:0]      out_instr1,
  output logic [31:0]      out_pc1,
  input  logic [1:0]       pop,
  output logic [CNT_W-1:0] count
`ifdef ISSUEQ_PERF_EN
  ,
  output logic [31:0]      perf_dual_issue,
  output logic [31:0]      perf_single_issue,
  output logic [31:0]      perf_empty
`endif
);
  iq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CNT_W-1:0] count_q, count_d, push_n, pop_req, pop_eff;
  // ready looks only at registered occupancy so pop never reaches fetch_ready combinationally
  assign fetch_ready = count_q <= CNT_W'(DEPTH - 2);
  assign head1 = head_q + PTR_W'(1);
  assign tail1 = tail_q + PTR_W'(1);
  // next-state: flush wins, otherwise apply clamped pop and accepted push together
  always_comb begin
    pop_req = CNT_W'(clamp_pop(pop));
    pop_eff = flush ? '0 : (pop_req > count_q ? count_q : pop_req);
    push_n  = (flush || !fetch_ready) ? '0 : fetch_valid == 2'b11 ? CNT_W'(2) : fetch_valid == 2'b01 ? CNT_W'(1) : '0;
    head_d  = flush ? '0 : head_q + PTR_W'(pop_eff);
    tail_d  = flush ? '0 : tail_q + PTR_W'(push_n);
    count_d = flush ? '0 : count_q + push_n - pop_eff;
  end
  // pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // entry storage, written in slot order at tail and tail+1; needs no reset
  always_ff @(posedge clk) begin
    if (push_n != '0) mem_q[tail_q] <= '{pc: fetch_pc0, instr: fetch_instr0};
    if (push_n == CNT_W'(2)) mem_q[tail1] <= '{pc: fetch_pc1, instr: fetch_instr1};
  end
  assign count      = count_q;
  assign out_valid0 = count_q != '0;
  assign out_valid1 = count_q >= CNT_W'(2);
  assign out_pc0    = out_valid0 ? mem_q[head_q].pc : '0;
  assign out_instr0 = out_valid0 ? mem_q[head_q].instr : '0;
  assign out_pc1    = out_valid1 ? mem_q[head1].pc : '0;
  assign out_instr1 = out_valid1 ? mem_q[head1].instr : '0;
`ifndef SYNTHESIS
  a_fetch_valid_legal: assert property (@(posedge clk) disable iff (!rst_n) fetch_valid != 2'b10)
    else $warning("issue_queue: fetch_valid=10 ignored");
  a_pop_in_range: assert property (@(posedge clk) disable iff (!rst_n) flush || pop_req <= count_q)
    else $warning("issue_queue: pop clamped to occupancy");
`endif
`ifdef ISSUEQ_PERF_EN
  issue_queue_perf u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .pop_eff_i(pop_eff[1:0]),
    .empty_i  (count_q == '0),
    .dual_o   (perf_dual_issue),
    .single_o (perf_single_issue),
    .empty_o  (perf_empty)
  );
`endif
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed and random checks of issue_queue against a queue-based reference model
module tb_issue_queue;
  localparam int DEPTH = 8;
  logic        clk = 0, rst_n = 0, flush = 0;
  logic [1:0]  fetch_valid = 0, pop = 0;
  logic [31:0] fetch_instr0 = 0, fetch_pc0 = 0, fetch_instr1 = 0, fetch_pc1 = 0;
  logic        fetch_ready, out_valid0, out_valid1;
  logic [31:0] out_instr0, out_pc0, out_instr1, out_pc1;
  logic [3:0]  count;
`ifdef ISSUEQ_PERF_EN
  logic [31:0] perf_dual_issue, perf_single_issue, perf_empty;
  int          m_dual = 0, m_single = 0, m_empty = 0;
`endif
  logic [63:0] q[$];
  int          n_chk = 0, n_fail = 0;

  issue_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_instr0(fetch_instr0), .fetch_pc0(fetch_pc0), .fetch_instr1(fetch_instr1), .fetch_pc1(fetch_pc1),
    .fetch_ready(fetch_ready), .out_valid0(out_valid0), .out_instr0(out_instr0), .out_pc0(out_pc0),
    .out_valid1(out_valid1), .out_instr1(out_instr1), .out_pc1(out_pc1), .pop(pop), .count(count)
`ifdef ISSUEQ_PERF_EN
    , .perf_dual_issue(perf_dual_issue), .perf_single_issue(perf_single_issue), .perf_empty(perf_empty)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_pc(int k);
    return q.size() > k ? q[k][63:32] : 32'h0;
  endfunction
  function automatic logic [31:0] m_instr(int k);
    return q.size() > k ? q[k][31:0] : 32'h0;
  endfunction

  // drive one cycle of stimulus and advance the reference model by the same rules
  task automatic step(input logic [1:0] fv, input logic [31:0] p0, i0, p1, i1, input logic [1:0] pp, input logic fl);
    int n;
    bit rdy;
    fetch_valid = fv; fetch_pc0 = p0; fetch_instr0 = i0; fetch_pc1 = p1; fetch_instr1 = i1; pop = pp; flush = fl;
    rdy = (DEPTH - q.size()) >= 2;
    n = (pp == 2'd3) ? 2 : int'(pp);
    if (n > q.size()) n = q.size();
`ifdef ISSUEQ_PERF_EN
    if (q.size() == 0) m_empty++;
    if (!fl && n == 2) m_dual++;
    if (!fl && n == 1) m_single++;
`endif
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      repeat (n) void'(q.pop_front());
      if (rdy && fv != 2'b00 && fv != 2'b10) q.push_back({p0, i0});
      if (rdy && fv == 2'b11) q.push_back({p1, i1});
    end
    fetch_valid = 0; pop = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_hold_count got=%0d exp=0", count); end
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      step(2'b00, 0, 0, 0, 0, 2'd0, 1'b0);
      n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", k, count); end
      n_chk++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", k, fetch_ready); end
      n_chk++; if ({out_valid0, out_valid1} !== 2'b00) begin n_fail++; $display("FAIL reset_valid cyc=%0d got=%b%b exp=00", k, out_valid0, out_valid1); end
    end
  endtask

  task automatic test_single_push();
    step(2'b11, 32'h100, 32'hAAAA_0001, 32'h104, 32'hAAAA_0002, 2'd0, 1'b0);
    n_chk++; if ({out_valid0, out_valid1} !== 2'b11) begin n_fail++; $display("FAIL push_valid got=%b%b exp=11", out_valid0, out_valid1); end
    n_chk++; if (out_pc0 !== 32'h100) begin n_fail++; $display("FAIL push_pc0 got=%h exp=100", out_pc0); end
    n_chk++; if (out_pc1 !== 32'h104) begin n_fail++; $display("FAIL push_pc1 got=%h exp=104", out_pc1); end
    n_chk++; if (out_instr1 !== 32'hAAAA_0002) begin n_fail++; $display("FAIL push_instr1 got=%h exp=aaaa0002", out_instr1); end
    n_chk++; if (count !== 4'd2) begin n_fail++; $display("FAIL push_count got=%0d exp=2", count); end
  endtask

  task automatic test_fill();
    step(2'b00, 0, 0, 0, 0, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) step(2'b11, 32'h200 + 8 * k, k, 32'h204 + 8 * k, k + 100, 2'd0, 1'b0);
    n_chk++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count got=%0d exp=8", count); end
    n_chk++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got=%b exp=0", fetch_ready); end
    step(2'b11, 32'h300, 1, 32'h304, 2, 2'd0, 1'b0);
    n_chk++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_push_count got=%0d exp=8", count); end
    n_chk++; if (out_pc0 !== 32'h200 || out_pc1 !== 32'h204) begin n_fail++; $display("FAIL full_push_head got=%h/%h exp=200/204", out_pc0, out_pc1); end
  endtask

  task automatic test_push_pop_wrap();
    step(2'b00, 0, 0, 0, 0, 2'd0, 1'b1);
    step(2'b11, 32'h400, 32'h1, 32'h404, 32'h2, 2'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      logic [31:0] p;
      p = 32'h400 + 8 * k;
      step(2'b11, p, ~p, p + 4, ~(p + 4), 2'd2, 1'b0);
      n_chk++; if (count !== 4'd2) begin n_fail++; $display("FAIL pp_count it=%0d got=%0d exp=2", k, count); end
      n_chk++; if (out_pc0 !== p || out_pc1 !== p + 4) begin n_fail++; $display("FAIL pp_pcs it=%0d got=%h/%h exp=%h/%h", k, out_pc0, out_pc1, p, p + 4); end
      n_chk++; if (out_instr0 !== ~p) begin n_fail++; $display("FAIL pp_instr0 it=%0d got=%h exp=%h", k, out_instr0, ~p); end
    end
  endtask

  task automatic test_flush();
    step(2'b00, 0, 0, 0, 0, 2'd0, 1'b1);
    step(2'b11, 32'h500, 0, 32'h504, 0, 2'd0, 1'b0);
    step(2'b11, 32'h508, 0, 32'h50c, 0, 2'd0, 1'b0);
    step(2'b01, 32'h510, 0, 32'h0, 0, 2'd0, 1'b0);
    n_chk++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    step(2'b11, 32'h5a0, 32'h5, 32'h5a4, 32'h6, 2'd1, 1'b1);
    n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count); end
    n_chk++; if ({out_valid0, out_valid1} !== 2'b00) begin n_fail++; $display("FAIL flush_valid got=%b%b exp=00", out_valid0, out_valid1); end
    n_chk++; if (out_pc0 !== 32'h0 || out_pc1 !== 32'h0) begin n_fail++; $display("FAIL flush_data got=%h/%h exp=0/0", out_pc0, out_pc1); end
    step(2'b00, 0, 0, 0, 0, 2'd0, 1'b0);
    n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_after_count got=%0d exp=0", count); end
  endtask

  task automatic test_overpop();
`ifdef ISSUEQ_PERF_EN
    int s0;
`endif
    step(2'b00, 0, 0, 0, 0, 2'd0, 1'b1);
    step(2'b01, 32'h600, 32'h66, 32'h0, 32'h0, 2'd0, 1'b0);
    n_chk++; if (count !== 4'd1 || out_pc0 !== 32'h600) begin n_fail++; $display("FAIL op_pre got=%0d/%h exp=1/600", count, out_pc0); end
`ifdef ISSUEQ_PERF_EN
    s0 = m_single;
`endif
    step(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL op_count got=%0d exp=0", count); end
    n_chk++; if (out_valid0 !== 1'b0 || fetch_ready !== 1'b1) begin n_fail++; $display("FAIL op_state got=v%b r%b exp=v0 r1", out_valid0, fetch_ready); end
`ifdef ISSUEQ_PERF_EN
    n_chk++; if (perf_single_issue !== 32'(s0 + 1)) begin n_fail++; $display("FAIL op_perf_single got=%0d exp=%0d", perf_single_issue, s0 + 1); end
`endif
  endtask

  task automatic test_async_reset();
    step(2'b11, 32'h700, 0, 32'h704, 0, 2'd0, 1'b0);
    step(2'b11, 32'h708, 0, 32'h70c, 0, 2'd1, 1'b0);
    #2 rst_n = 0;
    #1;
    n_chk++; if (count !== 4'd0 || out_valid0 !== 1'b0 || fetch_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset got=c%0d v%b r%b exp=c0 v0 r1", count, out_valid0, fetch_ready); end
`ifdef ISSUEQ_PERF_EN
    n_chk++; if (perf_dual_issue !== 0 || perf_single_issue !== 0 || perf_empty !== 0) begin n_fail++; $display("FAIL async_reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_dual_issue, perf_single_issue, perf_empty); end
    m_dual = 0; m_single = 0; m_empty = 0;
`endif
    q.delete();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      int s, r;
      logic [1:0] fv, pp;
      s = q.size();
      r = $urandom_range(0, 2);
      fv = (r == 2) ? 2'b11 : 2'(r);
      pp = 2'($urandom_range(0, s < 2 ? s : 2));
      if (s >= 2 && $urandom_range(0, 7) == 0) pp = 2'd3;
      step(fv, $urandom, $urandom, $urandom, $urandom, pp, $urandom_range(0, 29) == 0);
      n_chk++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", k, count, q.size()); end
      n_chk++; if (fetch_ready !== ((DEPTH - q.size()) >= 2)) begin n_fail++; $display("FAIL rnd_ready it=%0d got=%b exp=%b", k, fetch_ready, (DEPTH - q.size()) >= 2); end
      n_chk++; if ({out_valid0, out_valid1} !== {q.size() >= 1, q.size() >= 2}) begin n_fail++; $display("FAIL rnd_valid it=%0d got=%b%b size=%0d", k, out_valid0, out_valid1, q.size()); end
      n_chk++; if (out_pc0 !== m_pc(0) || out_instr0 !== m_instr(0)) begin n_fail++; $display("FAIL rnd_slot0 it=%0d got=%h/%h exp=%h/%h", k, out_pc0, out_instr0, m_pc(0), m_instr(0)); end
      n_chk++; if (out_pc1 !== m_pc(1) || out_instr1 !== m_instr(1)) begin n_fail++; $display("FAIL rnd_slot1 it=%0d got=%h/%h exp=%h/%h", k, out_pc1, out_instr1, m_pc(1), m_instr(1)); end
    end
`ifdef ISSUEQ_PERF_EN
    n_chk++; if (perf_dual_issue !== 32'(m_dual)) begin n_fail++; $display("FAIL rnd_perf_dual got=%0d exp=%0d", perf_dual_issue, m_dual); end
    n_chk++; if (perf_single_issue !== 32'(m_single)) begin n_fail++; $display("FAIL rnd_perf_single got=%0d exp=%0d", perf_single_issue, m_single); end
    n_chk++; if (perf_empty !== 32'(m_empty)) begin n_fail++; $display("FAIL rnd_perf_empty got=%0d exp=%0d", perf_empty, m_empty); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_push_pop_wrap();
    test_flush();
    test_overpop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
